device_delay_timer: RTL and testbench

//   Restartable one-shot delay timer for the OV7670 SCCB init sequencer.

---
 rtl/device_delay_timer_if.sv | 16 +
 rtl/device_delay_timer.sv | 72 +++++++
 tb/tb_device_delay_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/device_delay_timer_if.sv
// Control/status bundle between the SCCB init sequencer and its delay timer.
// syn_rst is a level restart request sampled on every posedge; delay_done is a level status (no valid/ready pairing).
interface device_delay_timer_if;
    logic syn_rst;
    logic delay_done;

    modport master (
        output syn_rst,
        input  delay_done
    );

    modport slave (
        input  syn_rst,
        output delay_done
    );
endinterface

// File: rtl/device_delay_timer.sv
// Restartable one-shot delay timer: counts DELAY_CYCLES clock edges after reset
// release or a synchronous restart, then raises delay_done and holds it.
module device_delay_timer #(
    parameter  int DELAY_CYCLES = 270000,
    localparam int CNT_W        = $clog2(DELAY_CYCLES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    device_delay_timer_if.slave    tmr,
    output logic                   dbg_state_o,
    output logic [CNT_W-1:0]       dbg_cnt_o
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        // Restart outranks terminal count, so a restart on the last edge keeps done low.
        if (tmr.syn_rst) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COUNT;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign tmr.delay_done = done_q;
    assign dbg_state_o    = state_q;
    assign dbg_cnt_o      = cnt_q;

endmodule

// File: tb/tb_device_delay_timer.sv
// Directed scoreboard bench for device_delay_timer with DELAY_CYCLES=8 and DELAY_CYCLES=1.
module tb_device_delay_timer;
  localparam int W = 7;  // {state8, done8, cnt8[3:0], done1}

  logic clk;
  logic rst_n;
  logic dbg_state8;
  logic [3:0] dbg_cnt8;
  logic dbg_state1;
  logic [0:0] dbg_cnt1;

  device_delay_timer_if if8();
  device_delay_timer_if if1();

  device_delay_timer #(.DELAY_CYCLES(8)) dut8 (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .tmr        (if8),
    .dbg_state_o(dbg_state8),
    .dbg_cnt_o  (dbg_cnt8)
  );

  device_delay_timer #(.DELAY_CYCLES(1)) dut1 (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .tmr        (if1),
    .dbg_state_o(dbg_state1),
    .dbg_cnt_o  (dbg_cnt1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // driver: drive syn_rst, let one edge pass, then queue what that edge must produce
  task automatic step(input logic syn, input logic e_done8, input logic [3:0] e_cnt8,
                      input logic e_done1);
    if8.syn_rst = syn;
    if1.syn_rst = syn;
    @(posedge clk);
    #1;
    exp_q.push_back({e_done8, e_done8, e_cnt8, e_done1});
  endtask

  // n consecutive counting edges after a (re)start: cnt8 saturates at 7, done8 from edge 8
  task automatic run_count(input int n);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, (k >= 8), (k >= 7) ? 4'd7 : 4'(k), 1'b1);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      exp_v = exp_q.pop_front();
      act_v = {dbg_state8, if8.delay_done, dbg_cnt8, if1.delay_done};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_check t=%0t got state8=%b done8=%b cnt8=%0d done1=%b expected state8=%b done8=%b cnt8=%0d done1=%b",
                 $time, act_v[6], act_v[5], act_v[4:1], act_v[0],
                 exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if8.syn_rst = 1'b0;
    if1.syn_rst = 1'b0;

    // reset state held across edges
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // 1: delay after reset release, then hold DONE for 20 more edges
    run_count(28);

    // 2: single-cycle restart from DONE
    step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(11);

    // 3: restart held high for 5 edges mid-count
    step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(10);

    // 4: short async reset pulse at count 5
    step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(5);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dbg_state8, if8.delay_done, dbg_cnt8, if1.delay_done} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset got state8=%b done8=%b cnt8=%0d done1=%b expected all zero",
               dbg_state8, if8.delay_done, dbg_cnt8, if1.delay_done);
    end
    #1;
    rst_n = 1'b1;
    run_count(10);

    // 5: restart on the terminal-count edge
    step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(7);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    run_count(9);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
